// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: controller states, gate index
// width and the gate-length lookup.
package freq_meter_pkg;

  localparam int GATE_IDX_W = 2;
  localparam int GATE_CNT_W = 30;

  typedef logic [GATE_IDX_W-1:0] gate_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    LATCH,
    RANGE,
    HOLD
  } state_t;

  // Gate length in sys_clk cycles: 1 ms scaled by 10^idx.
  function automatic logic [GATE_CNT_W-1:0] gate_len(input int unsigned clk_hz,
                                                     input gate_idx_t   idx);
    logic [63:0] len;
    len = 64'(clk_hz / 32'd1000);
    case (idx)
      2'd1:    len = len * 64'd10;
      2'd2:    len = len * 64'd100;
      2'd3:    len = len * 64'd1000;
      default: len = len;
    endcase
    return len[GATE_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Gate window down-counter: loads a length, counts down while enabled and
// parks at zero without wrapping.
module gate_timer
  import freq_meter_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [GATE_CNT_W-1:0] load_val,
  input  logic                  enable,
  output logic                  done
);

  logic [GATE_CNT_W-1:0] cnt_reg;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (enable && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - GATE_CNT_W'(1);
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate controller for a frequency counter: clears the edge counter, opens a
// timed gate window, latches the count and optionally auto-ranges the gate.
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter logic [31:0] LOW_THRESH  = 32'd1000,
  parameter logic [31:0] HIGH_THRESH = 32'd100_000_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        cont_mode,
  input  logic        auto_range,
  input  logic [1:0]  gate_sel,
  input  logic [31:0] cnt_value,
  output logic        cnt_clr,
  output logic        gate_en,
  output logic [31:0] result_cnt,
  output logic [1:0]  result_gate,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy
);

  localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t                state_reg, state_next;
  gate_idx_t             cur_sel_reg;
  gate_idx_t             auto_sel_reg, auto_sel_next;
  logic [SETTLE_W-1:0]   settle_cnt_reg;
  logic [31:0]           latched_reg;
  logic                  gate_done;
  logic                  settle_last;
  logic                  range_up;
  logic                  range_down;
  logic [GATE_CNT_W-1:0] gate_load_val;

  assign settle_last   = (settle_cnt_reg == SETTLE_W'(SETTLE_CYC - 1));
  assign range_up      = auto_range && (latched_reg < LOW_THRESH) && (cur_sel_reg != 2'd3);
  assign range_down    = auto_range && (latched_reg > HIGH_THRESH) && (cur_sel_reg != 2'd0);
  assign gate_load_val = gate_len(CLK_HZ, cur_sel_reg) - GATE_CNT_W'(1);

  gate_timer u_gate_timer (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .load     (state_reg == CLEAR),
    .load_val (gate_load_val),
    .enable   (state_reg == GATE),
    .done     (gate_done)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_clr       = 1'b0;
    gate_en       = 1'b0;
    auto_sel_next = auto_sel_reg;
    busy          = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        cnt_clr    = 1'b1;
        state_next = GATE;
      end
      GATE: begin
        gate_en = 1'b1;
        if (gate_done) state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_last) state_next = LATCH;
      end
      LATCH: begin
        state_next = RANGE;
      end
      RANGE: begin
        if (range_up) begin
          auto_sel_next = cur_sel_reg + 2'd1;
          state_next    = CLEAR;
        end else begin
          if (range_down) auto_sel_next = cur_sel_reg - 2'd1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (result_ready) state_next = cont_mode ? CLEAR : IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides everything and leaves the auto-range index untouched.
    if (abort) begin
      state_next    = IDLE;
      auto_sel_next = auto_sel_reg;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel_reg    <= '0;
      auto_sel_reg   <= '0;
      settle_cnt_reg <= '0;
      latched_reg    <= '0;
      result_cnt     <= '0;
      result_gate    <= '0;
      result_valid   <= 1'b0;
    end else begin
      auto_sel_reg <= auto_sel_next;
      if (state_next == CLEAR) begin
        cur_sel_reg <= auto_range ? auto_sel_next : gate_sel;
      end
      if (state_reg == SETTLE) begin
        settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
      end else begin
        settle_cnt_reg <= '0;
      end
      if (state_reg == LATCH) begin
        latched_reg <= cnt_value;
      end
      if (abort) begin
        result_valid <= 1'b0;
      end else if ((state_reg == RANGE) && !range_up) begin
        result_valid <= 1'b1;
        result_cnt   <= latched_reg;
        result_gate  <= cur_sel_reg;
      end else if ((state_reg == HOLD) && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl against a measurement-level model of
// gate sequencing, auto-ranging and result handshake.
module tb_freq_gate_ctrl;

  localparam int unsigned TB_CLK_HZ = 1000;
  localparam int unsigned TB_SETTLE = 4;
  localparam logic [31:0] TB_LOW    = 32'd1000;
  localparam logic [31:0] TB_HIGH   = 32'd100_000_000;

  logic        sys_clk;
  logic        rst_n;
  logic        start, abort, cont_mode, auto_range, result_ready;
  logic [1:0]  gate_sel;
  logic [31:0] cnt_value;
  logic        cnt_clr, gate_en, result_valid, busy;
  logic [31:0] result_cnt;
  logic [1:0]  result_gate;

  int errors = 0;
  int checks = 0;

  logic        ramp_mode;
  logic [31:0] ramp;
  logic [31:0] fixed_val;
  int          gate_run, clr_run;
  int          gate_runs[$];
  int          clr_runs[$];
  time         gate_fall_t, valid_t;
  int          model_auto;
  int          exp_gates[$];
  int          exp_rgate;

  freq_gate_ctrl #(
    .CLK_HZ      (TB_CLK_HZ),
    .SETTLE_CYC  (TB_SETTLE),
    .LOW_THRESH  (TB_LOW),
    .HIGH_THRESH (TB_HIGH)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cont_mode    (cont_mode),
    .auto_range   (auto_range),
    .gate_sel     (gate_sel),
    .cnt_value    (cnt_value),
    .cnt_clr      (cnt_clr),
    .gate_en      (gate_en),
    .result_cnt   (result_cnt),
    .result_gate  (result_gate),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  assign cnt_value = ramp_mode ? ramp : fixed_val;

  // Edge-counter emulation plus window-length monitor.
  always @(negedge sys_clk) begin
    if (cnt_clr) ramp = 32'd0;
    else if (gate_en) ramp = ramp + 32'd1;
    if (gate_en) gate_run++;
    else if (gate_run > 0) begin
      gate_runs.push_back(gate_run);
      gate_run    = 0;
      gate_fall_t = $time;
    end
    if (cnt_clr) clr_run++;
    else if (clr_run > 0) begin
      clr_runs.push_back(clr_run);
      clr_run = 0;
    end
  end

  function automatic int exp_len(input int idx);
    int l;
    l = int'(TB_CLK_HZ / 1000);
    for (int i = 0; i < idx; i++) l = l * 10;
    return l;
  endfunction

  // Predicts the sequence of gate windows and the reported gate for one run.
  task automatic model_predict(input bit au, input int sel, input logic [31:0] val);
    int idx;
    idx = au ? model_auto : sel;
    exp_gates.delete();
    exp_gates.push_back(exp_len(idx));
    if (au) begin
      while ((val < TB_LOW) && (idx < 3)) begin
        idx++;
        exp_gates.push_back(exp_len(idx));
      end
      model_auto = ((val > TB_HIGH) && (idx > 0)) ? idx - 1 : idx;
    end
    exp_rgate = idx;
  endtask

  task automatic pulse_start();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic measure(input int budget, output bit got);
    gate_runs.delete();
    clr_runs.delete();
    got = 1'b0;
    pulse_start();
    for (int c = 0; c < budget; c++) begin
      @(negedge sys_clk);
      if (result_valid) begin
        got     = 1'b1;
        valid_t = $time;
        break;
      end
    end
  endtask

  task automatic transfer();
    result_ready = 1'b1;
    @(negedge sys_clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({cnt_clr, gate_en, result_valid, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {cnt_clr, gate_en, result_valid, busy});
    end
    checks++;
    if ({result_cnt, result_gate} !== 34'd0) begin
      errors++;
      $display("FAIL reset_result: got cnt=%0d gate=%0d expected 0/0", result_cnt, result_gate);
    end
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_manual_gate();
    bit got;
    bit stable;
    ramp_mode = 1'b1; gate_sel = 2'd2; auto_range = 1'b0; cont_mode = 1'b0;
    measure(400, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL manual_valid: got %0b expected 1", got); end
    checks++;
    if (result_cnt !== 32'd100) begin errors++; $display("FAIL manual_cnt: got %0d expected 100", result_cnt); end
    checks++;
    if (result_gate !== 2'd2) begin errors++; $display("FAIL manual_gate: got %0d expected 2", result_gate); end
    checks++;
    if ((gate_runs.size() != 1) || (gate_runs[0] != 100)) begin
      errors++;
      $display("FAIL manual_gate_len: got n=%0d len=%0d expected n=1 len=100",
               gate_runs.size(), (gate_runs.size() > 0) ? gate_runs[0] : -1);
    end
    checks++;
    if ((clr_runs.size() != 1) || (clr_runs[0] != 1)) begin
      errors++;
      $display("FAIL manual_clr_len: got n=%0d len=%0d expected n=1 len=1",
               clr_runs.size(), (clr_runs.size() > 0) ? clr_runs[0] : -1);
    end
    checks++;
    if ((valid_t - gate_fall_t) / 10 != TB_SETTLE + 2) begin
      errors++;
      $display("FAIL manual_latency: got %0d expected %0d", (valid_t - gate_fall_t) / 10, TB_SETTLE + 2);
    end
    stable = 1'b1;
    gate_sel = 2'd0;
    repeat (5) begin
      @(negedge sys_clk);
      if (!result_valid || result_cnt !== 32'd100 || result_gate !== 2'd2) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL manual_hold: got unstable expected stable"); end
    transfer();
    checks++;
    if ({result_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL manual_release: got valid,busy=%b expected 00", {result_valid, busy});
    end
    $display("manual: cnt=%0d gate=%0d", result_cnt, result_gate);
  endtask

  task automatic check_run(input string name, input bit got, input logic [31:0] val);
    bit seq_ok;
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL %s_valid: got %0b expected 1", name, got); end
    checks++;
    if (result_cnt !== val) begin errors++; $display("FAIL %s_cnt: got %0d expected %0d", name, result_cnt, val); end
    checks++;
    if (int'(result_gate) != exp_rgate) begin
      errors++; $display("FAIL %s_gate: got %0d expected %0d", name, result_gate, exp_rgate);
    end
    seq_ok = (gate_runs.size() == exp_gates.size());
    if (seq_ok) foreach (exp_gates[i]) if (gate_runs[i] != exp_gates[i]) seq_ok = 1'b0;
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL %s_gate_seq: got %0d windows (last %0d) expected %0d windows (last %0d)", name,
               gate_runs.size(), (gate_runs.size() > 0) ? gate_runs[$] : -1,
               exp_gates.size(), exp_gates[$]);
    end
    $display("%s: cnt=%0d gate=%0d windows=%0d", name, result_cnt, result_gate, gate_runs.size());
  endtask

  task automatic test_auto_up();
    bit got;
    ramp_mode = 1'b0; fixed_val = 32'd10; auto_range = 1'b1; cont_mode = 1'b0;
    model_predict(1'b1, 0, fixed_val);
    measure(3000, got);
    check_run("auto_up", got, 32'd10);
    transfer();
  endtask

  task automatic test_auto_down();
    bit got;
    ramp_mode = 1'b0; fixed_val = 32'd200_000_000; auto_range = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model_predict(1'b1, 0, fixed_val);
      measure(3000, got);
      check_run("auto_down", got, fixed_val);
      transfer();
    end
  endtask

  task automatic test_back_to_back();
    int xfers = 0, clr_ok = 0, drops = 0;
    bit pend = 1'b0;
    bit idle_seen = 1'b0;
    ramp_mode = 1'b0; fixed_val = 32'd5; auto_range = 1'b0; gate_sel = 2'd0;
    cont_mode = 1'b1; result_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 200 && (xfers < 4 || pend); c++) begin
      @(negedge sys_clk);
      if (pend) begin
        if (cnt_clr) clr_ok++;
        pend = 1'b0;
      end
      if (!busy) drops++;
      if (result_valid && result_ready && xfers < 4) begin
        xfers++;
        pend = 1'b1;
      end
    end
    checks++;
    if (xfers != 4) begin errors++; $display("FAIL b2b_xfers: got %0d expected 4", xfers); end
    checks++;
    if (clr_ok != 4) begin errors++; $display("FAIL b2b_clear_after: got %0d expected 4", clr_ok); end
    checks++;
    if (drops != 0) begin errors++; $display("FAIL b2b_busy_drop: got %0d expected 0", drops); end
    cont_mode = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge sys_clk);
      if (!busy) begin idle_seen = 1'b1; break; end
    end
    result_ready = 1'b0;
    checks++;
    if (idle_seen !== 1'b1) begin errors++; $display("FAIL b2b_stop: got busy expected idle"); end
    $display("b2b: xfers=%0d clears=%0d drops=%0d", xfers, clr_ok, drops);
  endtask

  task automatic test_abort();
    bit quiet = 1'b1;
    ramp_mode = 1'b1; gate_sel = 2'd3; auto_range = 1'b0; cont_mode = 1'b0;
    pulse_start();
    repeat (20) @(negedge sys_clk);
    checks++;
    if (gate_en !== 1'b1) begin errors++; $display("FAIL abort_pre_gate: got %0b expected 1", gate_en); end
    abort = 1'b1; start = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({busy, gate_en, result_valid} !== 3'b000) begin
      errors++; $display("FAIL abort_idle: got busy,gate,valid=%b expected 000", {busy, gate_en, result_valid});
    end
    abort = 1'b0; start = 1'b0;
    repeat (30) begin
      @(negedge sys_clk);
      if (busy || result_valid || gate_en) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL abort_quiet: got activity expected none"); end
    $display("abort: busy=%0b valid=%0b", busy, result_valid);
  endtask

  task automatic test_reset_mid_gate();
    bit got;
    bit quiet = 1'b1;
    ramp_mode = 1'b1; gate_sel = 2'd2; auto_range = 1'b0; cont_mode = 1'b0;
    pulse_start();
    repeat (30) @(negedge sys_clk);
    checks++;
    if (gate_en !== 1'b1) begin errors++; $display("FAIL rst_pre_gate: got %0b expected 1", gate_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt_clr, gate_en, result_valid, busy, result_cnt, result_gate} !== 38'd0) begin
      errors++;
      $display("FAIL rst_async: got clr=%0b gate=%0b valid=%0b busy=%0b cnt=%0d rg=%0d expected all 0",
               cnt_clr, gate_en, result_valid, busy, result_cnt, result_gate);
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
    model_auto = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (result_valid || busy) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL rst_no_result: got activity expected none"); end
    gate_sel = 2'd1;
    model_predict(1'b0, 1, 32'd0);
    measure(400, got);
    check_run("rst_restart", got, 32'(exp_len(1)));
    transfer();
  endtask

  task automatic test_random();
    bit got;
    bit au;
    int sel;
    int cls;
    ramp_mode = 1'b0; cont_mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      au  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      cls = int'($urandom_range(0, 2));
      case (cls)
        0:       fixed_val = $urandom_range(0, 999);
        1:       fixed_val = $urandom_range(1000, 100_000_000);
        default: fixed_val = 32'd100_000_001 + $urandom_range(0, 1_000_000_000);
      endcase
      auto_range = au;
      gate_sel   = 2'(sel);
      model_predict(au, sel, fixed_val);
      measure(4000, got);
      check_run("random", got, fixed_val);
      transfer();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont_mode = 1'b0; auto_range = 1'b0;
    result_ready = 1'b0; gate_sel = 2'd0; ramp_mode = 1'b0; ramp = 32'd0; fixed_val = 32'd0;
    gate_run = 0; clr_run = 0; gate_fall_t = 0; valid_t = 0; model_auto = 0; exp_rgate = 0;
    test_reset();
    test_manual_gate();
    test_auto_up();
    test_auto_down();
    test_back_to_back();
    test_abort();
    test_reset_mid_gate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
